sig_align_pipe: RTL and testbench

- Parametrised, pipelined significand alignment unit for the multi-operand FP adder tree in the GEMM/FFT datapath.
- Takes LANES packed low-precision operands and finds the maximum exponent itself.
- Right-shifts each lane's hidden-bit significand by its exponent offset, with sticky capture, and emits signed two's-complement fixed-point words ready for direct summation.
- Valid/ready handshake on both sides; 2-stage pipeline with full-throughput backpressure.

---
 rtl/sig_align_pipe.sv | 143 ++++++++++++++
 tb/tb_sig_align_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_align_pipe.sv
// Two-stage significand alignment for the multi-operand FP adder tree.
// Define SIG_ALIGN_STICKY_JAM_EN to OR each lane's sticky into the LSB before negation.
module sig_align_pipe #(
  parameter int LANES      = 4,
  parameter int EXP_WIDTH  = 3,
  parameter int SIG_WIDTH  = 3,
  parameter int LOW_EXPAND = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES*EXP_WIDTH-1:0]      in_exp,
  input  logic [LANES*SIG_WIDTH-1:0]      in_sig,
  input  logic [LANES-1:0]                in_sign,
  input  logic [LANES-1:0]                in_zero,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [EXP_WIDTH-1:0]            out_max_exp,
  output logic [LANES*(SIG_WIDTH+4+LOW_EXPAND)-1:0] out_fix,
  output logic [LANES-1:0]                out_sticky
);

  localparam int FIXWIDTH = SIG_WIDTH + 4 + LOW_EXPAND;
  localparam int MAGW     = FIXWIDTH - 1;

  logic                       s1_valid_q;
  logic [EXP_WIDTH-1:0]       s1_max_exp_q;
  logic [LANES*EXP_WIDTH-1:0] s1_off_q;
  logic [LANES*SIG_WIDTH-1:0] s1_sig_q;
  logic [LANES-1:0]           s1_sign_q;
  logic [LANES-1:0]           s1_zero_q;

  logic                       out_valid_q;
  logic [EXP_WIDTH-1:0]       out_max_exp_q;
  logic [LANES*FIXWIDTH-1:0]  out_fix_q;
  logic [LANES-1:0]           out_sticky_q;

  logic                       s1_load;
  logic                       s2_load;
  logic [EXP_WIDTH-1:0]       max_exp_d;
  logic [LANES*EXP_WIDTH-1:0] off_d;
  logic [LANES*FIXWIDTH-1:0]  fix_d;
  logic [LANES-1:0]           sticky_d;

  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // Zero lanes are excluded so their exponent fields cannot inflate the max.
  always_comb begin
    max_exp_d = '0;
    off_d     = '0;
    // NOTE: blocking assignments here are intentional; the running max must be
    // visible to the next loop iteration within the same evaluation.
    for (int i = 0; i < LANES; i++) begin
      if (!in_zero[i] && in_exp[i*EXP_WIDTH +: EXP_WIDTH] > max_exp_d)
        max_exp_d = in_exp[i*EXP_WIDTH +: EXP_WIDTH];
    end
    for (int i = 0; i < LANES; i++)
      off_d[i*EXP_WIDTH +: EXP_WIDTH] = max_exp_d - in_exp[i*EXP_WIDTH +: EXP_WIDTH];
  end

  always_comb begin
    logic [EXP_WIDTH-1:0] off;
    logic [MAGW-1:0]      mag;
    logic [MAGW-1:0]      sh;
    logic [FIXWIDTH-1:0]  lane;
    logic                 stk;
    fix_d    = '0;
    sticky_d = '0;
    off      = '0;
    mag      = '0;
    sh       = '0;
    lane     = '0;
    stk      = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      off = s1_off_q[i*EXP_WIDTH +: EXP_WIDTH];
      mag = s1_zero_q[i] ? '0
          : {2'b00, 1'b1, s1_sig_q[i*SIG_WIDTH +: SIG_WIDTH], {LOW_EXPAND{1'b0}}};
      if (int'(off) >= MAGW) begin
        sh  = '0;
        stk = |mag;
      end else begin
        sh  = mag >> off;
        stk = |(mag & ~({MAGW{1'b1}} << off));
      end
`ifdef SIG_ALIGN_STICKY_JAM_EN
      lane = {1'b0, sh | {{(MAGW-1){1'b0}}, stk}};
`else
      lane = {1'b0, sh};
`endif
      fix_d[i*FIXWIDTH +: FIXWIDTH] = s1_sign_q[i] ? (~lane + {{(FIXWIDTH-1){1'b0}}, 1'b1})
                                                   : lane;
      sticky_d[i] = stk;
    end
  end

  // NOTE: asynchronous reset clears every register, so in-flight data is
  // dropped the moment rst rises, not at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_max_exp_q <= '0;
      s1_off_q     <= '0;
      s1_sig_q     <= '0;
      s1_sign_q    <= '0;
      s1_zero_q    <= '0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_max_exp_q <= max_exp_d;
        s1_off_q     <= off_d;
        s1_sig_q     <= in_sig;
        s1_sign_q    <= in_sign;
        s1_zero_q    <= in_zero;
      end
    end
  end

  // Output registers only move on s2_load, which holds data stable under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_max_exp_q <= '0;
      out_fix_q     <= '0;
      out_sticky_q  <= '0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_max_exp_q <= s1_max_exp_q;
        out_fix_q     <= fix_d;
        out_sticky_q  <= sticky_d;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_max_exp = out_max_exp_q;
  assign out_fix     = out_fix_q;
  assign out_sticky  = out_sticky_q;

endmodule

// File: tb/tb_sig_align_pipe.sv
// Self-checking bench for sig_align_pipe: vector table, scoreboard, and
// hand sequences for latency, backpressure, reset and exponent saturation.
module tb_sig_align_pipe;

  typedef struct {
    logic [11:0] exp;
    logic [11:0] sig;
    logic [3:0]  sign;
    logic [3:0]  zero;
    logic [2:0]  max_exp;
    logic [35:0] fix;
    logic [3:0]  sticky;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [11:0] in_exp, in_sig;
  logic [3:0]  in_sign, in_zero, out_sticky;
  logic [2:0]  out_max_exp;
  logic [35:0] out_fix;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [15:0] in_exp4;
  logic [11:0] in_sig4;
  logic [3:0]  in_sign4, in_zero4, out_sticky4;
  logic [3:0]  out_max_exp4;
  logic [35:0] out_fix4;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pops   = 0;
  vec_t sb[$];
  vec_t mon_exp;
  vec_t tbl[6];
  vec_t va, vb, vc;

  always #5 clk = ~clk;

  sig_align_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_exp(in_exp), .in_sig(in_sig), .in_sign(in_sign), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max_exp(out_max_exp), .out_fix(out_fix), .out_sticky(out_sticky)
  );

  sig_align_pipe #(.EXP_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_exp(in_exp4), .in_sig(in_sig4), .in_sign(in_sign4), .in_zero(in_zero4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_max_exp(out_max_exp4), .out_fix(out_fix4), .out_sticky(out_sticky4)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference written as integer arithmetic: divide for the shift, remainder for sticky.
  function automatic vec_t model(input logic [11:0] e, input logic [11:0] s,
                                 input logic [3:0] sg, input logic [3:0] z);
    vec_t v;
    int mx, off, mag, sh, fx;
    logic stk;
    v.exp = e; v.sig = s; v.sign = sg; v.zero = z;
    v.fix = '0; v.sticky = '0;
    mx = 0;
    for (int i = 0; i < 4; i++)
      if (!z[i] && int'(e[i*3 +: 3]) > mx) mx = int'(e[i*3 +: 3]);
    v.max_exp = 3'(mx);
    for (int i = 0; i < 4; i++) begin
      mag = z[i] ? 0 : (8 + int'(s[i*3 +: 3])) * 4;
      off = mx - int'(e[i*3 +: 3]);
      if (off < 0) off = 0;
      sh  = mag / (1 << off);
      stk = (mag % (1 << off)) != 0;
`ifdef SIG_ALIGN_STICKY_JAM_EN
      if (stk) sh = sh | 1;
`endif
      fx = sg[i] ? (512 - sh) % 512 : sh;
      v.fix[i*9 +: 9] = 9'(fx);
      v.sticky[i] = stk;
    end
    return v;
  endfunction

  function automatic vec_t mk(input logic [11:0] e, input logic [11:0] s, input logic [3:0] sg,
                              input logic [3:0] z, input logic [2:0] mx,
                              input logic [35:0] fx, input logic [3:0] st);
    vec_t v;
    v.exp = e; v.sig = s; v.sign = sg; v.zero = z;
    v.max_exp = mx; v.fix = fx; v.sticky = st;
    return v;
  endfunction

  // Outputs transfer on the next rising edge when valid && ready are seen here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", {63'd0, out_valid}, 64'd0);
      end else begin
        mon_exp = sb.pop_front();
        check("out_max_exp", {61'd0, out_max_exp}, {61'd0, mon_exp.max_exp});
        check("out_fix", {28'd0, out_fix}, {28'd0, mon_exp.fix});
        check("out_sticky", {60'd0, out_sticky}, {60'd0, mon_exp.sticky});
        n_pops++;
      end
    end
  end

  task automatic push(input vec_t v);
    int guard;
    in_exp = v.exp; in_sig = v.sig; in_sign = v.sign; in_zero = v.zero;
    in_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    else sb.push_back(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops_before;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_exp = '0; in_sig = '0; in_sign = '0; in_zero = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    in_exp4 = '0; in_sig4 = '0; in_sign4 = '0; in_zero4 = '0;

    tbl[0] = mk({3'd0, 3'd3, 3'd5, 3'd5}, {4{3'b101}}, 4'b0000, 4'b0000, 3'd5,
                {9'h001, 9'h00D, 9'h034, 9'h034}, 4'b1000);
    tbl[1] = mk({3'd0, 3'd3, 3'd5, 3'd5}, {4{3'b101}}, 4'b0001, 4'b0000, 3'd5,
                {9'h001, 9'h00D, 9'h034, 9'h1CC}, 4'b1000);
    tbl[2] = mk({3'd7, 3'd6, 3'd5, 3'd4}, {4{3'b101}}, 4'b0000, 4'b1111, 3'd0,
                36'd0, 4'b0000);
    tbl[3] = mk({3'd2, 3'd2, 3'd2, 3'd7}, {4{3'b101}}, 4'b0000, 4'b0001, 3'd2,
                {9'h034, 9'h034, 9'h034, 9'h000}, 4'b0000);
    tbl[4] = mk({4{3'd4}}, {3'b000, 3'b111, 3'b010, 3'b001}, 4'b1010, 4'b0000, 3'd4,
                {9'h1E0, 9'h03C, 9'h1D8, 9'h024}, 4'b0000);
`ifdef SIG_ALIGN_STICKY_JAM_EN
    tbl[5] = mk({3'd0, 3'd0, 3'd0, 3'd7}, {4{3'b111}}, 4'b0000, 4'b0000, 3'd7,
                {9'h001, 9'h001, 9'h001, 9'h03C}, 4'b1110);
`else
    tbl[5] = mk({3'd0, 3'd0, 3'd0, 3'd7}, {4{3'b111}}, 4'b0000, 4'b0000, 3'd7,
                {9'h000, 9'h000, 9'h000, 9'h03C}, 4'b1110);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_fix", {28'd0, out_fix}, 64'd0);
    check("rst_out_max_exp", {61'd0, out_max_exp}, 64'd0);
    check("rst_out_sticky", {60'd0, out_sticky}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Two-cycle latency from accept.
    push(tbl[0]);
    check("lat_cycle1_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    check("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
    drain();

    for (int i = 0; i < 6; i++) push(tbl[i]);
    drain();

    // Random traffic with random downstream stalls.
    fork
      begin
        repeat (80) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 30; i++)
          push(model(12'($urandom), 12'($urandom), 4'($urandom),
                     4'($urandom) & 4'($urandom) & 4'($urandom)));
      end
    join
    out_ready = 1'b1;
    drain();

    // Backpressure: A and B fill both stages, C must wait.
    va = tbl[4]; vb = tbl[1]; vc = tbl[3];
    out_ready = 1'b0;
    push(va);
    push(vb);
    in_exp = vc.exp; in_sig = vc.sig; in_sign = vc.sign; in_zero = vc.zero;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      check("bp_hold_fix", {28'd0, out_fix}, {28'd0, va.fix});
    end
    pops_before = n_pops;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    if (in_ready) sb.push_back(vc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_b_consecutive", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_c_consecutive", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    check("bp_pop_count", 64'(n_pops - pops_before), 64'd3);
    drain();

    // Reset with both stages occupied.
    out_ready = 1'b0;
    push(tbl[0]);
    push(tbl[1]);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_out_fix", {28'd0, out_fix}, 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("postrst_no_stale", {63'd0, out_valid}, 64'd0);
    end
    check("postrst_in_ready", {63'd0, in_ready}, 64'd1);

    // Wide exponent: offset 12 saturates past MAGW=8.
    @(posedge clk); #1;
    in_exp4 = {4'd0, 4'd0, 4'd0, 4'd12};
    in_sig4 = '0; in_sign4 = '0; in_zero4 = '0;
    in_valid4 = 1'b1;
    @(negedge clk);
    check("w4_in_ready", {63'd0, in_ready4}, 64'd1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("w4_out_valid", {63'd0, out_valid4}, 64'd1);
    check("w4_max_exp", {60'd0, out_max_exp4}, 64'd12);
`ifdef SIG_ALIGN_STICKY_JAM_EN
    check("w4_fix", {28'd0, out_fix4}, {28'd0, 9'h001, 9'h001, 9'h001, 9'h020});
`else
    check("w4_fix", {28'd0, out_fix4}, {28'd0, 9'h000, 9'h000, 9'h000, 9'h020});
`endif
    check("w4_sticky", {60'd0, out_sticky4}, 64'b1110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
